// File: rtl/fetch_pc_generator_pkg.sv
// Shared fetch-stage types: BTB geometry, entry layout, PC-to-index/tag helpers and FSM encodings.
package fetch_pc_generator_pkg;

    localparam int PKG_ADDR_WIDTH    = 32;
    localparam int PKG_BTB_ENTRY_NUM = 64;
    localparam int IDX_W             = $clog2(PKG_BTB_ENTRY_NUM);
    localparam int TAG_W             = PKG_ADDR_WIDTH - IDX_W - 2;

    typedef logic [PKG_ADDR_WIDTH-1:0] PC;
    typedef logic [IDX_W-1:0]          BTBIndex;
    typedef logic [TAG_W-1:0]          BTBTag;

    typedef struct packed {
        logic  valid;
        BTBTag tag;
        PC     target;
    } BTB_Entry;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic BTBIndex ToBTB_Index(input PC pc);
        return pc[IDX_W+1:2];
    endfunction

    function automatic BTBTag ToBTB_Tag(input PC pc);
        return pc[PKG_ADDR_WIDTH-1:IDX_W+2];
    endfunction

endpackage

// File: rtl/fetch_pc_generator_branch_target_buffer.sv
// Direct-mapped BTB: combinational lookup, registered write, and a per-index clear used by the init sweep.
module branch_target_buffer
    import fetch_pc_generator_pkg::*;
(
    input  logic    clk,
    input  PC       lookup_pc_i,
    output logic    hit_o,
    output PC       target_o,
    input  logic    wr_en_i,
    input  PC       wr_pc_i,
    input  PC       wr_target_i,
    input  logic    clr_en_i,
    input  BTBIndex clr_idx_i
);

    BTB_Entry entries_q [PKG_BTB_ENTRY_NUM];
    BTB_Entry rd_entry;
    logic     unused_low_bits;

    // Byte-offset bits never take part in indexing or tagging.
    assign unused_low_bits = ^{lookup_pc_i[1:0], wr_pc_i[1:0]};

    assign rd_entry = entries_q[ToBTB_Index(lookup_pc_i)];
    assign hit_o    = rd_entry.valid && (rd_entry.tag == ToBTB_Tag(lookup_pc_i));
    assign target_o = rd_entry.target;

    // No reset on storage: the init sweep clears every valid bit before lookups matter.
    always_ff @(posedge clk) begin
        if (clr_en_i) begin
            entries_q[clr_idx_i].valid <= 1'b0;
        end
        if (wr_en_i) begin
            entries_q[ToBTB_Index(wr_pc_i)] <= '{valid: 1'b1,
                                                 tag: ToBTB_Tag(wr_pc_i),
                                                 target: wr_target_i};
        end
    end

endmodule

// File: rtl/fetch_pc_generator.sv
// Fetch PC register and next-PC select; sweeps the BTB clear after reset before fetching.
module fetch_pc_generator
    import fetch_pc_generator_pkg::*;
#(
    parameter int                    ADDR_WIDTH    = PKG_ADDR_WIDTH,
    parameter int                    BTB_ENTRY_NUM = PKG_BTB_ENTRY_NUM,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  pred_taken,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  pc_valid,
    output logic                  predicted_taken,
    output logic [ADDR_WIDTH-1:0] predicted_next
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    logic [0:0]            state_q, state_d;
    BTBIndex               sweep_q, sweep_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] seq_pc, sel_next, redirect_aligned;
    logic                  run, btb_hit, take;
    PC                     btb_target;

    assign run              = (state_q == ST_RUN);
    assign seq_pc           = pc_q + ADDR_WIDTH'(4);
    assign redirect_aligned = redirect_pc & ALIGN_MASK;
    assign take             = pred_taken && btb_hit;
    assign sel_next         = take ? btb_target : seq_pc;

    assign pc               = pc_q;
    assign pc_valid         = run;
    assign predicted_taken  = run && take;
    assign predicted_next   = run ? sel_next : '0;

    branch_target_buffer u_btb (
        .clk         (clk),
        .lookup_pc_i (pc_q),
        .hit_o       (btb_hit),
        .target_o    (btb_target),
        .wr_en_i     (run && upd_valid && upd_taken),
        .wr_pc_i     (upd_pc),
        .wr_target_i (upd_target & ALIGN_MASK),
        .clr_en_i    (!run),
        .clr_idx_i   (sweep_q)
    );

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        pc_d    = pc_q;
        if (state_q == ST_INIT) begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == BTBIndex'(BTB_ENTRY_NUM - 1)) begin
                state_d = ST_RUN;
            end
            if (redirect_valid) begin
                pc_d = redirect_aligned;
            end
        end else begin
            if (redirect_valid) begin
                pc_d = redirect_aligned;
            end else if (!stall) begin
                pc_d = sel_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_generator.sv
// Self-checking bench for fetch_pc_generator: directed scenarios plus randomized traffic against a reference model.
module tb_fetch_pc_generator;

    localparam int NENT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        pred_taken = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic [31:0] pc;
    logic        pc_valid;
    logic        predicted_taken;
    logic [31:0] predicted_next;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: remaining init cycles, current PC, and BTB contents keyed by the trained branch PC.
    int          m_init_left = NENT;
    logic [31:0] m_pc = '0;
    bit          m_valid [NENT];
    logic [31:0] m_bpc   [NENT];
    logic [31:0] m_tgt   [NENT];

    always #5 clk = ~clk;

    fetch_pc_generator dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .pred_taken      (pred_taken),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .pc              (pc),
        .pc_valid        (pc_valid),
        .predicted_taken (predicted_taken),
        .predicted_next  (predicted_next)
    );

    function automatic int slot(input logic [31:0] a);
        return int'((a / 4) % NENT);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[slot(a)] && ((m_bpc[slot(a)] / (4 * NENT)) == (a / (4 * NENT)));
    endfunction

    function automatic bit exp_taken();
        return (m_init_left == 0) && pred_taken && m_hit(m_pc);
    endfunction

    function automatic logic [31:0] exp_next();
        if (m_init_left != 0) return 32'h0;
        if (exp_taken()) return m_tgt[slot(m_pc)];
        return m_pc + 32'd4;
    endfunction

    task automatic tick();
        logic [31:0] npc;
        int          nleft;
        npc   = m_pc;
        nleft = m_init_left;
        if (rst) begin
            nleft = NENT;
            npc   = 32'h0;
            for (int i = 0; i < NENT; i++) m_valid[i] = 1'b0;
        end else if (m_init_left > 0) begin
            nleft = m_init_left - 1;
            if (redirect_valid) npc = redirect_pc - (redirect_pc % 4);
        end else begin
            if (redirect_valid) npc = redirect_pc - (redirect_pc % 4);
            else if (!stall)    npc = exp_next();
            if (upd_valid && upd_taken) begin
                m_valid[slot(upd_pc)] = 1'b1;
                m_bpc[slot(upd_pc)]   = upd_pc;
                m_tgt[slot(upd_pc)]   = upd_target - (upd_target % 4);
            end
        end
        @(posedge clk);
        m_pc        = npc;
        m_init_left = nleft;
        #1;
    endtask

    task automatic clear_inputs();
        rst = 1'b0; stall = 1'b0; pred_taken = 1'b0; redirect_valid = 1'b0;
        upd_valid = 1'b0; upd_taken = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        clear_inputs();
        for (int i = 0; i < NENT; i++) begin
            #2;
            n_vec++;
            if (pc_valid !== 1'b0 || pc !== 32'h0 || predicted_taken !== 1'b0) begin
                n_err++;
                $display("FAIL reset_sweep cyc=%0d: got valid=%b pc=%h pt=%b, need valid=0 pc=0 pt=0",
                         i, pc_valid, pc, predicted_taken);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            #2;
            n_vec++;
            if (pc_valid !== 1'b1 || pc !== 32'(i * 4)) begin
                n_err++;
                $display("FAIL reset_seq step=%0d: got valid=%b pc=%h, need valid=1 pc=%h",
                         i, pc_valid, pc, 32'(i * 4));
            end
            tick();
        end
    endtask

    task automatic test_btb_hit();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        upd_valid = 1'b1; upd_taken = 1'b1; upd_pc = 32'h100; upd_target = 32'h200;
        tick();
        clear_inputs();
        pred_taken = 1'b1;
        #2;
        n_vec++;
        if (pc !== 32'h100 || predicted_taken !== 1'b1 || predicted_next !== 32'h200) begin
            n_err++;
            $display("FAIL btb_hit_taken: got pc=%h pt=%b pn=%h, need pc=100 pt=1 pn=200",
                     pc, predicted_taken, predicted_next);
        end
        tick();
        n_vec++;
        if (pc !== 32'h200) begin
            n_err++;
            $display("FAIL btb_hit_follow: got pc=%h, need 200", pc);
        end
        pred_taken = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        clear_inputs();
        #2;
        n_vec++;
        if (predicted_taken !== 1'b0 || predicted_next !== 32'h104) begin
            n_err++;
            $display("FAIL btb_hit_not_taken: got pt=%b pn=%h, need pt=0 pn=104",
                     predicted_taken, predicted_next);
        end
        tick();
        n_vec++;
        if (pc !== 32'h104) begin
            n_err++;
            $display("FAIL btb_not_taken_follow: got pc=%h, need 104", pc);
        end
    endtask

    task automatic test_alias();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        clear_inputs();
        pred_taken = 1'b1;
        #2;
        n_vec++;
        if (pc !== 32'h200 || predicted_taken !== 1'b0 || predicted_next !== 32'h204) begin
            n_err++;
            $display("FAIL alias_miss: got pc=%h pt=%b pn=%h, need pc=200 pt=0 pn=204",
                     pc, predicted_taken, predicted_next);
        end
        tick();
        pred_taken = 1'b0;
    endtask

    task automatic test_stall_redirect();
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h403;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_vec++;
            if (pc !== 32'h400) begin
                n_err++;
                $display("FAIL stall_hold cyc=%0d: got pc=%h, need 400", i, pc);
            end
            tick();
        end
        clear_inputs();
        #2;
        n_vec++;
        if (pc !== 32'h400) begin
            n_err++;
            $display("FAIL stall_release: got pc=%h, need 400", pc);
        end
        tick();
        n_vec++;
        if (pc !== 32'h404) begin
            n_err++;
            $display("FAIL stall_resume: got pc=%h, need 404", pc);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        clear_inputs();
        #2;
        n_vec++;
        if (predicted_next !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_next: got pn=%h, need 00000000", predicted_next);
        end
        tick();
        n_vec++;
        if (pc !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_pc: got pc=%h, need 00000000", pc);
        end
    endtask

    task automatic test_reset_mid_sweep();
        rst = 1'b1;
        tick();
        clear_inputs();
        for (int i = 0; i < 30; i++) tick();
        rst = 1'b1;
        tick();
        clear_inputs();
        for (int i = 0; i < NENT; i++) begin
            upd_valid = 1'b1; upd_taken = 1'b1; upd_pc = 32'h300; upd_target = 32'h500;
            redirect_valid = (i == 10); redirect_pc = 32'h80;
            #2;
            n_vec++;
            if (pc_valid !== 1'b0) begin
                n_err++;
                $display("FAIL resweep_valid cyc=%0d: got valid=%b, need 0", i, pc_valid);
            end
            tick();
        end
        clear_inputs();
        #2;
        n_vec++;
        if (pc_valid !== 1'b1 || pc !== 32'h80) begin
            n_err++;
            $display("FAIL resweep_first: got valid=%b pc=%h, need valid=1 pc=80", pc_valid, pc);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h100; pred_taken = 1'b1;
        #2;
        n_vec++;
        if (predicted_taken !== 1'b0 || predicted_next !== 32'h304) begin
            n_err++;
            $display("FAIL init_upd_ignored: got pt=%b pn=%h, need pt=0 pn=304",
                     predicted_taken, predicted_next);
        end
        tick();
        clear_inputs();
        pred_taken = 1'b1;
        #2;
        n_vec++;
        if (predicted_taken !== 1'b0) begin
            n_err++;
            $display("FAIL sweep_cleared_old: got pt=%b, need 0", predicted_taken);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        logic [31:0] pool [8];
        pool = '{32'h100, 32'h104, 32'h200, 32'h1100, 32'h1104, 32'hFFFF_FFFC, 32'h40, 32'h140};
        for (int i = 0; i < 1500; i++) begin
            rst            = ($urandom_range(0, 299) == 0);
            stall          = ($urandom_range(0, 3) == 0);
            pred_taken     = $urandom_range(0, 1) == 1;
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc    = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            upd_valid      = ($urandom_range(0, 2) == 0);
            upd_taken      = $urandom_range(0, 1) == 1;
            upd_pc         = pool[$urandom_range(0, 7)];
            upd_target     = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            #2;
            n_vec++;
            if (pc !== m_pc || pc_valid !== (m_init_left == 0) ||
                predicted_taken !== exp_taken() || predicted_next !== exp_next()) begin
                n_err++;
                $display("FAIL random cyc=%0d: got pc=%h v=%b pt=%b pn=%h, need pc=%h v=%b pt=%b pn=%h",
                         i, pc, pc_valid, predicted_taken, predicted_next,
                         m_pc, (m_init_left == 0), exp_taken(), exp_next());
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        for (int i = 0; i < NENT; i++) begin
            m_valid[i] = 1'b0; m_bpc[i] = '0; m_tgt[i] = '0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_btb_hit();
        test_alias();
        test_stall_redirect();
        test_wrap();
        test_reset_mid_sweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
